// File: rtl/pe_mac_stream.sv
// Systolic MAC processing element: forwards operands right/down, accumulates
// valid pairs into a framed dot product and publishes it with a valid pulse.
module pe_mac_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] up_i,
  input  logic                  up_valid_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic                  left_valid_i,
  input  logic                  last_i,
  input  logic                  clear_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] down_o,
  output logic                  down_valid_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  right_valid_o,
  output logic                  right_last_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  output logic                  res_ovf_o
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int PW = 2*DATA_WIDTH;

  logic          fire;
  logic [PW-1:0] a_ext, b_ext, prod;
  logic [AW-1:0] acc_q, base, sum_fin;
  logic [AW:0]   base_ext, prod_ext, sum;
  logic          ovf_q, ovf_base, overflow;

  always_comb begin
    fire     = up_valid_i & left_valid_i;
    // Operands extended to full product width: low PW bits of the product
    // are then correct for both signed and unsigned interpretation.
    a_ext    = {{(PW-DW){signed_i & up_i[DW-1]}}, up_i};
    b_ext    = {{(PW-DW){signed_i & left_i[DW-1]}}, left_i};
    prod     = a_ext * b_ext;
    base     = clear_i ? '0 : acc_q;
    ovf_base = ~clear_i & ovf_q;
    base_ext = {signed_i & base[AW-1], base};
    prod_ext = {{(AW+1-PW){signed_i & prod[PW-1]}}, prod};
    sum      = base_ext + prod_ext;
    overflow = signed_i ? (sum[AW] ^ sum[AW-1]) : sum[AW];
    sum_fin  = sum[AW-1:0];
    if (SATURATE && overflow) begin
      if (!signed_i)    sum_fin = '1;
      else if (sum[AW]) sum_fin = {1'b1, {(AW-1){1'b0}}};
      else              sum_fin = {1'b0, {(AW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      down_o        <= '0;
      down_valid_o  <= 1'b0;
      right_o       <= '0;
      right_valid_o <= 1'b0;
      right_last_o  <= 1'b0;
      res_o         <= '0;
      res_valid_o   <= 1'b0;
      res_ovf_o     <= 1'b0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      down_o        <= up_i;
      down_valid_o  <= up_valid_i;
      right_o       <= left_i;
      right_valid_o <= left_valid_i;
      right_last_o  <= last_i;
      res_valid_o   <= fire & last_i;
      if (fire && last_i) begin
        res_o     <= sum_fin;
        res_ovf_o <= ovf_base | overflow;
        acc_q     <= '0;
        ovf_q     <= 1'b0;
      end else if (fire) begin
        acc_q <= sum_fin;
        ovf_q <= ovf_base | overflow;
      end else if (clear_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: directed test-plan frames plus random traffic,
// checked against an integer-arithmetic model for both saturate and wrap.
module tb_pe_mac_stream;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam longint MOD  = longint'(1) << AW;
  localparam longint MASK = MOD - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, uv, lv, last, clr, sgn;
  logic [DW-1:0] up, left;

  logic [DW-1:0] down [2];
  logic [DW-1:0] right [2];
  logic          dv [2], rvld [2], rl [2], resv [2], rovf [2];
  logic [AW-1:0] res [2];

  // Instance 0 saturates, instance 1 wraps; both see identical stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pe_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(g == 0)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .up_i(up), .up_valid_i(uv), .left_i(left), .left_valid_i(lv),
      .last_i(last), .clear_i(clr), .signed_i(sgn),
      .down_o(down[g]), .down_valid_o(dv[g]), .right_o(right[g]),
      .right_valid_o(rvld[g]), .right_last_o(rl[g]),
      .res_o(res[g]), .res_valid_o(resv[g]), .res_ovf_o(rovf[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state (values stored as unsigned AW-bit patterns)
  longint m_acc [2], m_res [2];
  bit     m_ovf [2], m_rovf [2];
  bit     m_rv;
  logic [DW-1:0] m_down, m_right;
  bit     m_dv, m_rvld, m_rl;

  function automatic longint as_val(longint bits, int w, bit s);
    longint v = bits & ((longint'(1) << w) - 1);
    if (s && v >= (longint'(1) << (w-1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic model_edge();
    longint a, b, base, sum, lo, hi, r;
    bit ov;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        m_acc[s] = 0; m_res[s] = 0; m_ovf[s] = 0; m_rovf[s] = 0;
      end
      m_rv = 0; m_down = '0; m_right = '0; m_dv = 0; m_rvld = 0; m_rl = 0;
      return;
    end
    m_down = up; m_dv = uv; m_right = left; m_rvld = lv; m_rl = last;
    m_rv = 0;
    if (uv && lv) begin
      a  = as_val(longint'(up), DW, sgn);
      b  = as_val(longint'(left), DW, sgn);
      lo = sgn ? -(longint'(1) << (AW-1)) : 0;
      hi = sgn ? (longint'(1) << (AW-1)) - 1 : MASK;
      for (int s = 0; s < 2; s++) begin
        base = clr ? 0 : as_val(m_acc[s], AW, sgn);
        sum  = base + a * b;
        ov   = (sum > hi) || (sum < lo);
        if (ov && s == 0) r = (sum > hi) ? hi : lo;
        else              r = sum;
        r = r & MASK;
        if (last) begin
          m_res[s]  = r;
          m_rovf[s] = (clr ? 1'b0 : m_ovf[s]) | ov;
          m_acc[s]  = 0;
          m_ovf[s]  = 0;
        end else begin
          m_acc[s] = r;
          m_ovf[s] = (clr ? 1'b0 : m_ovf[s]) | ov;
        end
      end
      m_rv = last;
    end else if (clr) begin
      for (int s = 0; s < 2; s++) begin
        m_acc[s] = 0; m_ovf[s] = 0;
      end
    end
  endtask

  // Drive at negedge, update model at posedge, compare at next negedge.
  task automatic cyc(input logic r, input logic u_v, input logic [DW-1:0] u,
                     input logic l_v, input logic [DW-1:0] l, input logic la,
                     input logic c, input logic sg);
    rst = r; uv = u_v; up = u; lv = l_v; left = l; last = la; clr = c; sgn = sg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("down%0d", s),  {dv[s], down[s]},  {m_dv, m_down});
      chk($sformatf("right%0d", s), {rl[s], rvld[s], right[s]}, {m_rl, m_rvld, m_right});
      chk($sformatf("resv%0d", s),  resv[s], m_rv);
      chk($sformatf("res%0d", s),   {rovf[s], res[s]}, {m_rovf[s], m_res[s][AW-1:0]});
    end
  endtask

  task automatic pair(input logic [DW-1:0] u, input logic [DW-1:0] l,
                      input logic la, input logic sg);
    cyc(1'b0, 1'b1, u, 1'b1, l, la, 1'b0, sg);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, DW'($urandom), 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; uv = 0; lv = 0; up = '0; left = '0; last = 0; clr = 0; sgn = 0;
    @(negedge clk);
    // 1: reset with random inputs, then forwarding
    repeat (2) cyc(1'b1, 1'b1, DW'($urandom), 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
    chk("rst_res", {resv[0], rovf[0], res[0], dv[0], down[0]}, '0);
    idle(); idle();
    // 2: unsigned dot product
    pair(8'd3, 8'd4, 0, 0); pair(8'd5, 8'd6, 0, 0); pair(8'd7, 8'd8, 1, 0);
    chk("t2_res", {resv[0], rovf[0], res[0]}, {1'b1, 1'b0, 16'h0062});
    idle();
    chk("t2_pulse", resv[0], 1'b0);
    // 3: signed
    pair(8'hFE, 8'h03, 0, 1); pair(8'h04, 8'hFB, 1, 1);
    chk("t3_res", {rovf[0], res[0]}, {1'b0, 16'hFFE6});
    // 4: gaps on left valid
    pair(8'd2, 8'd2, 0, 0);
    repeat (3) cyc(1'b0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
    pair(8'd3, 8'd3, 1, 0);
    chk("t4_res", res[0], 16'd13);
    // 5: overflow, saturate vs wrap; next frame clean
    pair(8'd255, 8'd255, 0, 0); pair(8'd255, 8'd255, 1, 0);
    chk("t5_sat", {rovf[0], res[0]}, {1'b1, 16'hFFFF});
    chk("t5_wrap", {rovf[1], res[1]}, {1'b1, 16'hFC02});
    pair(8'd1, 8'd2, 1, 0);
    chk("t5_next", {rovf[0], res[0]}, {1'b0, 16'd2});
    // 6: clear with last, and reset mid-frame
    pair(8'd10, 8'd10, 0, 0);
    cyc(1'b0, 1'b1, 8'd2, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
    chk("t6_clr", res[0], 16'd6);
    pair(8'd10, 8'd10, 0, 0);
    cyc(1'b1, 1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    chk("t6_rstv", resv[0], 1'b0);
    pair(8'd1, 8'd1, 1, 0);
    chk("t6_rst", {resv[0], res[0]}, {1'b1, 16'd1});
    // signed saturation both directions
    pair(8'h80, 8'h80, 0, 1); pair(8'h80, 8'h80, 0, 1); pair(8'h7F, 8'h7F, 1, 1);
    chk("sat_pos", {rovf[0], res[0]}, {1'b1, 16'h7FFF});
    pair(8'h80, 8'h7F, 0, 1); pair(8'h80, 8'h7F, 0, 1); pair(8'h80, 8'h7F, 1, 1);
    chk("sat_neg", {rovf[0], res[0]}, {1'b1, 16'h8000});
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), DW'($urandom),
          ($urandom_range(0, 9) < 8), DW'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
